// File: rtl/lr35902_joy_pkg.sv
// rtl/lr35902_joy_pkg.sv - shared types and button bit positions for the serial gamepad bridge
package lr35902_joy_pkg;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_LATCH,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } joy_state_e;

    // Pad shift order on the wire equals the buttons bit order
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/lr35902_joy_pad_if.sv
// rtl/lr35902_joy_pad_if.sv - pad pins and P1 matrix lines; master is the bridge, slave is board/register side
interface lr35902_joy_pad_if;

    logic       pad_latch;
    logic       pad_clk;
    logic       pad_data;
    logic       p14;
    logic       p15;
    logic       p10;
    logic       p11;
    logic       p12;
    logic       p13;
    logic [7:0] buttons;
    logic       scan_done;

    modport master (
        output pad_latch, pad_clk, p10, p11, p12, p13, buttons, scan_done,
        input  pad_data, p14, p15
    );

    modport slave (
        input  pad_latch, pad_clk, p10, p11, p12, p13, buttons, scan_done,
        output pad_data, p14, p15
    );

endinterface

// File: rtl/lr35902_joy_tick.sv
// rtl/lr35902_joy_tick.sv - phase timer: tick_o on the last cycle of every CLK_DIV-cycle phase
module lr35902_joy_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    output logic tick_o
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    // restart_i marks a state entry, so the new phase begins at count 0
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lr35902_joy_pad.sv
// rtl/lr35902_joy_pad.sv - scans a serial gamepad and drives the P1 matrix; LR35902_JOY_DEBOUNCE_EN adds two-scan debounce
module lr35902_joy_pad
    import lr35902_joy_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int POLL_CYCLES = 16384
) (
    input  logic         clk,
    input  logic         reset,
    lr35902_joy_pad_if.master jp
);

    localparam int            PW        = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);

    joy_state_e    state_q, state_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    raw_q, raw_d;
    logic [7:0]    btn_q, btn_d;
`ifdef LR35902_JOY_DEBOUNCE_EN
    logic [7:0]    prev_q, prev_d;
`endif
    logic          scan_start;
    logic          tick;
    logic          restart;
    logic          sel_dir;
    logic          sel_btn;

    // Free-running poll counter keeps scan starts exactly POLL_CYCLES apart
    assign scan_start = (poll_q == POLL_LAST);
    assign poll_d     = scan_start ? '0 : poll_q + 1'b1;
    assign restart    = (state_d != state_q);

    lr35902_joy_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .restart_i (restart),
        .tick_o    (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        raw_d   = raw_q;
        btn_d   = btn_q;
`ifdef LR35902_JOY_DEBOUNCE_EN
        prev_d  = prev_q;
`endif
        case (state_q)
            ST_WAIT: begin
                if (scan_start) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    idx_d   = '0;
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tick) begin
                    raw_d[idx_q] = ~jp.pad_data;
                    state_d      = (idx_q == 3'd7) ? ST_DONE : ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_LOW;
                end
            end
            ST_DONE: begin
`ifdef LR35902_JOY_DEBOUNCE_EN
                if (raw_q == prev_q) begin
                    btn_d = raw_q;
                end
                prev_d = raw_q;
`else
                btn_d = raw_q;
`endif
                state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT;
            poll_q  <= POLL_LAST;
            idx_q   <= '0;
            raw_q   <= '0;
            btn_q   <= '0;
`ifdef LR35902_JOY_DEBOUNCE_EN
            prev_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
            idx_q   <= idx_d;
            raw_q   <= raw_d;
            btn_q   <= btn_d;
`ifdef LR35902_JOY_DEBOUNCE_EN
            prev_q  <= prev_d;
`endif
        end
    end

    assign jp.pad_latch = (state_q == ST_LATCH);
    assign jp.pad_clk   = (state_q == ST_HIGH);
    assign jp.scan_done = (state_q == ST_DONE);
    assign jp.buttons   = btn_q;

    // Selects are active low; a line is pulled low if any selected button on it is pressed
    assign sel_dir = ~jp.p14;
    assign sel_btn = ~jp.p15;
    assign jp.p10  = ~((sel_dir & btn_q[BTN_RIGHT]) | (sel_btn & btn_q[BTN_A]));
    assign jp.p11  = ~((sel_dir & btn_q[BTN_LEFT])  | (sel_btn & btn_q[BTN_B]));
    assign jp.p12  = ~((sel_dir & btn_q[BTN_UP])    | (sel_btn & btn_q[BTN_SELECT]));
    assign jp.p13  = ~((sel_dir & btn_q[BTN_DOWN])  | (sel_btn & btn_q[BTN_START]));

endmodule

// File: tb/tb_lr35902_joy_pad.sv
// tb/tb_lr35902_joy_pad.sv - scoreboard bench for lr35902_joy_pad with a shift-register pad model
module tb_lr35902_joy_pad;

    typedef struct packed {
        logic [7:0] btn;
        logic [3:0] p;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rel_cyc = 0;
    exp_t exp_q[$];
    logic done_prev = 1'b0;
    logic overlap = 1'b0;
    logic [7:0] pad_pressed = 8'h00;
    logic [7:0] pad_sr = 8'hFF;
    logic [7:0] m_btn = 8'h00;
    logic [7:0] m_prev = 8'h00;

    lr35902_joy_pad_if jif ();

    lr35902_joy_pad #(
        .CLK_DIV     (2),
        .POLL_CYCLES (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .jp    (jif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) rel_cyc <= 0;
        else       rel_cyc <= rel_cyc + 1;
    end

    // Pad: parallel load on latch, shift toward bit 0 on each pad_clk rise
    always @(posedge jif.pad_latch or posedge jif.pad_clk) begin
        if (jif.pad_latch) pad_sr <= ~pad_pressed;
        else               pad_sr <= {1'b1, pad_sr[7:1]};
    end
    assign jif.pad_data = pad_sr[0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [3:0] exp_p(input logic [7:0] b, input logic s14, input logic s15);
        logic [3:0] p;
        p[0] = !((!s14 & b[7]) | (!s15 & b[0]));
        p[1] = !((!s14 & b[6]) | (!s15 & b[1]));
        p[2] = !((!s14 & b[4]) | (!s15 & b[2]));
        p[3] = !((!s14 & b[5]) | (!s15 & b[3]));
        return p;
    endfunction

    function automatic logic [3:0] dut_p();
        return {jif.p13, jif.p12, jif.p11, jif.p10};
    endfunction

    task automatic model_scan(input logic [7:0] pressed);
`ifdef LR35902_JOY_DEBOUNCE_EN
        if (pressed == m_prev) m_btn = pressed;
        m_prev = pressed;
`else
        m_btn = pressed;
`endif
    endtask

    // Monitor: one cycle after scan_done the registered result must match the head of the queue
    always @(negedge clk) begin : mon
        exp_t e;
        if (jif.pad_latch && jif.pad_clk) overlap = 1'b1;
        if (reset) begin
            done_prev = 1'b0;
        end else begin
            if (done_prev && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scan_buttons", jif.buttons, e.btn);
                check("scan_p13_p10", dut_p(), e.p);
            end
            done_prev = jif.scan_done;
        end
    end

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!jif.scan_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL scan_done_timeout: got no pulse expected one within 200 cycles");
        end
    endtask

    task automatic run_scan(input logic [7:0] pressed, input logic s14, input logic s15,
                            input logic mid, input logic m14, input logic m15);
        exp_t       e;
        logic [7:0] old_btn;
        int         n = 0;
        pad_pressed = pressed;
        jif.p14 = s14;
        jif.p15 = s15;
        old_btn = m_btn;
        model_scan(pressed);
        e.btn = m_btn;
        e.p   = mid ? exp_p(m_btn, m14, m15) : exp_p(m_btn, s14, s15);
        exp_q.push_back(e);
        if (mid) begin
            while (!jif.pad_latch && n < 100) begin
                @(negedge clk);
                n++;
            end
            jif.p14 = m14;
            jif.p15 = m15;
            #1;
            check("midscan_select_p", dut_p(), exp_p(old_btn, m14, m15));
        end
        wait_done();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int   lat_first;
        int   lat_cnt;
        int   clk_rises;
        int   done_cyc;
        logic prev_clk;
        logic prev_lat;
        int   rises[$];
        int   n;
        exp_t e;

        jif.p14 = 1'b1;
        jif.p15 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_buttons", jif.buttons, 8'h00);
        check("rst_pad_latch", jif.pad_latch, 1'b0);
        check("rst_pad_clk", jif.pad_clk, 1'b0);
        check("rst_scan_done", jif.scan_done, 1'b0);
        check("rst_p13_p10", dut_p(), 4'b1111);

        model_scan(8'h00);
        e.btn = m_btn;
        e.p   = exp_p(m_btn, 1'b1, 1'b1);
        exp_q.push_back(e);
        reset = 1'b0;
        lat_first = -1; lat_cnt = 0; clk_rises = 0; done_cyc = -1; prev_clk = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (jif.pad_latch) begin
                if (lat_first < 0) lat_first = rel_cyc;
                lat_cnt++;
            end
            if (jif.pad_clk && !prev_clk) clk_rises++;
            prev_clk = jif.pad_clk;
            if (jif.scan_done && done_cyc < 0) done_cyc = rel_cyc;
        end
        check("first_latch_cycle", lat_first, 1);
        check("latch_width", lat_cnt, 2);
        check("pad_clk_rises", clk_rises, 7);
        check("scan_done_cycle", done_cyc, 33);

        run_scan(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_scan(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_scan(8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        run_scan(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_scan(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        run_scan(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_scan(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_scan(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_scan(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_scan(8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_scan(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_scan(8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_scan(8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        n = 0;
        while (!jif.pad_clk && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_high_phase", jif.pad_clk, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_pad_clk", jif.pad_clk, 1'b0);
        check("abort_pad_latch", jif.pad_latch, 1'b0);
        check("abort_buttons", jif.buttons, 8'h00);
        check("abort_scan_done", jif.scan_done, 1'b0);
        check("abort_queue_empty", exp_q.size(), 0);
        m_btn = 8'h00;
        m_prev = 8'h00;
        @(negedge clk);

        pad_pressed = 8'h24;
        jif.p14 = 1'b0;
        jif.p15 = 1'b0;
        model_scan(8'h24);
        e.btn = m_btn;
        e.p   = exp_p(m_btn, 1'b0, 1'b0);
        exp_q.push_back(e);
        reset = 1'b0;
        @(negedge clk);
        check("fresh_latch_after_reset", jif.pad_latch, 1'b1);
        rises.push_back(rel_cyc);
        prev_lat = jif.pad_latch;
        n = 0;
        while (rises.size() < 5 && n < 400) begin
            @(negedge clk);
            n++;
            if (jif.pad_latch && !prev_lat) rises.push_back(rel_cyc);
            prev_lat = jif.pad_latch;
        end
        check("latch_rise_count", rises.size(), 5);
        for (int i = 1; i < rises.size(); i++) begin
            check("poll_spacing", rises[i] - rises[i-1], 64);
        end

        check("queue_drained", exp_q.size(), 0);
        check("latch_clk_overlap", overlap, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lr35902_joy_pad.md
# lr35902_joy_pad

Sequences an external serial gamepad (parallel-load shift register: latch, clock, data) and presents the result as the Game Boy P1 button matrix. Periodically scans 8 buttons, optionally debounces them, and drives `p10`..`p13` for the joypad register block from its `p14`/`p15` select outputs. Sits between the board pins and `lr35902_joy`.

## Interface
- `CLK_DIV`, 4: `clk` cycles per pad-clock phase (latch width, low phase, high phase); must be ≥1.
- `POLL_CYCLES`, 16384: `clk` cycles from one scan start to the next; must be > 16*`CLK_DIV`+1.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `pad_latch`  out  1  parallel-load strobe to the pad, active high.
- `pad_clk`  out  1  shift clock to the pad; the pad shifts on the rising edge.
- `pad_data`  in  1  serial data from the pad, low = pressed.
- `p14`  in  1  direction select from the joypad register, low = selected.
- `p15`  in  1  button select from the joypad register, low = selected.
- `p10`..`p13`  out  1 each  matrix return lines to the joypad register, low = pressed.
- `buttons`  out  8  current state, 1 = pressed; bit order {Right,Left,Down,Up,Start,Select,B,A} (bit 0 = A).
- `scan_done`  out  1  one-cycle pulse when a scan completes.

## Operation
- FSM states: WAIT, LATCH, LOW, HIGH, DONE.
- WAIT: poll counter runs. When it reaches `POLL_CYCLES`-1, it moves to LATCH and the counter restarts at 0. The counter runs in every state, so scan starts are exactly `POLL_CYCLES` apart.
- LATCH: `pad_latch`=1 for `CLK_DIV` cycles, then LOW with bit index 0.
- LOW: `pad_clk`=0 for `CLK_DIV` cycles. On the last cycle of LOW, `pad_data` is inverted and stored into raw bit [index].
  - If index=7, go to DONE.
  - Otherwise go to HIGH.
- HIGH: `pad_clk`=1 for `CLK_DIV` cycles, index increments, then LOW.
- DONE: lasts one cycle. `scan_done`=1, `buttons` is updated (see Configuration), then WAIT.
- Pad bit order on the wire: A, B, Select, Start, Up, Down, Left, Right. Raw bit i maps to `buttons` bit i.
- Matrix outputs are combinational from `buttons`, `p14` and `p15`:
  - `p10` = !((!p14 & Right) | (!p15 & A))
  - `p11` = !((!p14 & Left) | (!p15 & B))
  - `p12` = !((!p14 & Up) | (!p15 & Select))
  - `p13` = !((!p14 & Down) | (!p15 & Start))
  - Both selected: lines are the OR of both groups (low if either is pressed). Neither selected: 1111.
- A select change mid-scan takes effect on `p10`..`p13` immediately; the scan is unaffected.

## Timing
- Reset values:
  - outputs: `buttons`=0, `pad_latch`=0, `pad_clk`=0, `scan_done`=0, so `p10`..`p13`=1.
  - internals: FSM=WAIT, poll counter = `POLL_CYCLES`-1, raw and previous-raw registers = 0.
- The first scan's LATCH begins on the first cycle after `reset` deasserts.
- Scan length: LATCH to last LOW cycle is 16*`CLK_DIV` cycles, plus 1 DONE cycle. `pad_clk` shows 7 rising edges per scan.
- `buttons` changes on the cycle after DONE (registered), coincident with `scan_done` deasserting. `p10`..`p13` follow in the same cycle.
- `reset` asserted mid-scan aborts it: all reset values are applied on the next edge and no partial update reaches `buttons`.
- `pad_latch` and `pad_clk` are never high simultaneously.

## Configuration
- `LR35902_JOY_DEBOUNCE_EN` defined:
  - In DONE, `buttons` is loaded only if the raw scan equals the previous scan's raw value. A change therefore needs two consecutive identical scans.
  - The previous-raw register is updated every DONE.
  - `scan_done` pulses on every scan regardless.
- Not defined: `buttons` is loaded from raw on every DONE, and there is no previous-raw register.

## Structure
- Package `lr35902_joy_pkg`:
  - FSM state enum.
  - Button bit index constants (`BTN_A`…`BTN_RIGHT`).
- Sub-module `lr35902_joy_tick`: phase counter producing a `tick` every `CLK_DIV` cycles, restarted by the FSM on every state entry.
- Top module: FSM, bit index, poll counter, raw/previous/state registers, matrix logic.

## Test plan
Bench configuration: `CLK_DIV`=2, `POLL_CYCLES`=64; a pad model shifts on `pad_clk` rising edges.
- Reset release with no buttons pressed (pad model returns all 1s) → `pad_latch` high 2 cycles starting the cycle after release; 7 `pad_clk` rising edges; `scan_done` at cycle 33 after release; `buttons`=0x00; `p10`..`p13`=1111.
- Pad A+Up pressed, `p15`=0 `p14`=1 → `buttons`=0x11 (debounce off) and `p10..p13`=0111 (`p10` low). Then `p14`=0 `p15`=1 → `p12` low only (0b1011 as `p13..p10`).
- Both selects low with Right and A pressed → `p10`=0; all other lines 1. Neither select low → all lines 1.
- `LR35902_JOY_DEBOUNCE_EN`, Start pressed for exactly one scan → `buttons` stays 0x00. Start held for two scans → bit 3 set after the second `scan_done`.
- `reset` pulsed during a HIGH phase → next cycle `pad_clk`=0, `pad_latch`=0, `buttons`=0; a fresh LATCH follows reset release.
- Poll spacing check → consecutive `pad_latch` rising edges exactly 64 cycles apart over 4 scans.
